ht_res_collector: RTL and testbench

Result-side endpoint of the hash table's command/result protocol. Sits on the `ht_res_if` output of `hash_table_top` and replaces the permanently-ready sink with a real consumer. It applies `ready` backpressure, buffers results in a FIFO and forwards them downstream over valid/ready. It also tracks outstanding commands against the `ht_cmd_if` handshake, and keeps per-rescode statistics plus a drain indication for software and bench use.

---
 rtl/ht_res_collector.sv | 121 ++++++++++++
 tb/tb_ht_res_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ht_res_collector.sv
// Result-side consumer for the hash table: buffers results in a FIFO, forwards them
// downstream, counts results per rescode and tracks outstanding commands.
module ht_res_collector #(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int OUTST_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_fire_i,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  logic [1:0]             res_opcode_i,
  input  logic [KEY_WIDTH-1:0]   res_key_i,
  input  logic [VALUE_WIDTH-1:0] res_value_i,
  input  logic [2:0]             res_rescode_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [1:0]             out_opcode_o,
  output logic [KEY_WIDTH-1:0]   out_key_o,
  output logic [VALUE_WIDTH-1:0] out_value_o,
  output logic [2:0]             out_rescode_o,
  input  logic [2:0]             stat_sel_i,
  output logic [CNT_WIDTH-1:0]   stat_cnt_o,
  input  logic                   stat_clr_i,
  output logic [OUTST_WIDTH-1:0] outstanding_o,
  output logic                   drain_done_o,
  output logic                   err_unexp_o,
  output logic                   err_outst_ovf_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [1:0]             mem_opcode  [FIFO_DEPTH];
  logic [KEY_WIDTH-1:0]   mem_key     [FIFO_DEPTH];
  logic [VALUE_WIDTH-1:0] mem_value   [FIFO_DEPTH];
  logic [2:0]             mem_rescode [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         occ;
  logic                   push, pop;
  logic [CNT_WIDTH-1:0]   stat_cnt [8];
  logic [OUTST_WIDTH-1:0] outstanding;

  assign res_ready_o = (occ != FULL_OCC);
  assign out_valid_o = (occ != '0);
  assign push        = res_valid_i && res_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign out_opcode_o  = mem_opcode[rd_ptr];
  assign out_key_o     = mem_key[rd_ptr];
  assign out_value_o   = mem_value[rd_ptr];
  assign out_rescode_o = mem_rescode[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_opcode[i]  <= '0;
        mem_key[i]     <= '0;
        mem_value[i]   <= '0;
        mem_rescode[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_opcode[wr_ptr]  <= res_opcode_i;
        mem_key[wr_ptr]     <= res_key_i;
        mem_value[wr_ptr]   <= res_value_i;
        mem_rescode[wr_ptr] <= res_rescode_i;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment; counters saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      for (int i = 0; i < 8; i++) stat_cnt[i] <= '0;
    end else if (push && (stat_cnt[res_rescode_i] != '1)) begin
      stat_cnt[res_rescode_i] <= stat_cnt[res_rescode_i] + CNT_WIDTH'(1);
    end
  end

  assign stat_cnt_o = stat_cnt[stat_sel_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding     <= '0;
      err_unexp_o     <= 1'b0;
      err_outst_ovf_o <= 1'b0;
    end else begin
      case ({cmd_fire_i, push})
        2'b10: begin
          if (outstanding == '1) err_outst_ovf_o <= 1'b1;
          else                   outstanding     <= outstanding + OUTST_WIDTH'(1);
        end
        2'b01: begin
          if (outstanding == '0) err_unexp_o <= 1'b1;
          else                   outstanding <= outstanding - OUTST_WIDTH'(1);
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign outstanding_o = outstanding;
  assign drain_done_o  = (outstanding == '0) && (occ == '0);

endmodule

// File: tb/tb_ht_res_collector.sv
// Bench for ht_res_collector: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_ht_res_collector;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;
  localparam int OMAX  = 255;

  logic        clk = 0, rst = 1;
  logic        cmd_fire = 0, res_valid = 0, out_ready = 0, stat_clr = 0;
  logic [1:0]  res_opcode = 0;
  logic [31:0] res_key = 0;
  logic [15:0] res_value = 0;
  logic [2:0]  res_rescode = 0, stat_sel = 0;
  logic        res_ready, out_valid, drain_done, err_unexp, err_ovf;
  logic [1:0]  out_opcode;
  logic [31:0] out_key;
  logic [15:0] out_value;
  logic [2:0]  out_rescode;
  logic [CW-1:0] stat_cnt;
  logic [7:0]  outstanding;

  int checks = 0, failures = 0;
  bit started = 0;

  typedef struct {
    logic [1:0] op; logic [31:0] key; logic [15:0] val; logic [2:0] rc;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_popped[$];
  int          m_stat[8];
  int          m_outst;
  bit          m_unexp, m_ovf;

  ht_res_collector #(.KEY_WIDTH(32), .VALUE_WIDTH(16), .FIFO_DEPTH(DEPTH),
                     .CNT_WIDTH(CW), .OUTST_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_fire_i(cmd_fire),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_opcode_i(res_opcode), .res_key_i(res_key), .res_value_i(res_value),
    .res_rescode_i(res_rescode), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_opcode_o(out_opcode), .out_key_o(out_key), .out_value_o(out_value),
    .out_rescode_o(out_rescode), .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt),
    .stat_clr_i(stat_clr), .outstanding_o(outstanding), .drain_done_o(drain_done),
    .err_unexp_o(err_unexp), .err_outst_ovf_o(err_ovf));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level behaviour of the collector.
  always @(posedge clk) begin
    bit acc, rel;
    if (rst) begin
      m_q.delete();
      foreach (m_stat[i]) m_stat[i] = 0;
      m_outst = 0; m_unexp = 0; m_ovf = 0;
    end else begin
      acc = res_valid && (m_q.size() < DEPTH);
      rel = out_ready && (m_q.size() > 0);
      if (rel) begin
        m_popped.push_back(m_q[0].key);
        void'(m_q.pop_front());
      end
      if (acc) m_q.push_back('{res_opcode, res_key, res_value, res_rescode});
      if (stat_clr) foreach (m_stat[i]) m_stat[i] = 0;
      else if (acc && m_stat[res_rescode] < SMAX) m_stat[res_rescode]++;
      if (cmd_fire && !acc) begin
        if (m_outst == OMAX) m_ovf = 1; else m_outst++;
      end else if (acc && !cmd_fire) begin
        if (m_outst == 0) m_unexp = 1; else m_outst--;
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("res_ready", res_ready, m_q.size() < DEPTH);
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_opcode", out_opcode, m_q[0].op);
      chk("out_key", out_key, m_q[0].key);
      chk("out_value", out_value, m_q[0].val);
      chk("out_rescode", out_rescode, m_q[0].rc);
    end
    chk("stat_cnt", stat_cnt, m_stat[stat_sel]);
    chk("outstanding", outstanding, m_outst);
    chk("drain_done", drain_done, (m_outst == 0) && (m_q.size() == 0));
    chk("err_unexp", err_unexp, m_unexp);
    chk("err_ovf", err_ovf, m_ovf);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    res_valid = 0; cmd_fire = 0; stat_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); step(); rst = 0;
  endtask

  // Present a result and hold it until the model says it was accepted.
  task automatic send(logic [31:0] key, logic [2:0] rc);
    bit acc;
    res_valid = 1; res_key = key; res_rescode = rc;
    res_opcode = key[1:0]; res_value = key[15:0] ^ 16'h5a5a;
    for (int n = 0; n < 50; n++) begin
      acc = (m_q.size() < DEPTH);
      step();
      if (acc) return;
    end
    chk("send_timeout", 1, 0);
  endtask

  initial begin
    step(); step();
    rst = 0; started = 1;
    chk("rst_ready", res_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_key", out_key, 0);
    chk("rst_drain", drain_done, 1);

    // Three commands then three results, consumed immediately
    cmd_fire = 1; step(); step(); step(); cmd_fire = 0;
    out_ready = 1;
    send(32'h11, 2);
    chk("lat1_valid", out_valid, 1);
    chk("lat1_key", out_key, 32'h11);
    send(32'h22, 2);
    chk("lat2_key", out_key, 32'h22);
    send(32'h33, 0);
    idle(); step();
    stat_sel = 2; #1 chk("stat2", stat_cnt, 2);
    stat_sel = 0; #1 chk("stat0", stat_cnt, 1);
    chk("s1_outst", outstanding, 0);
    chk("s1_drain", drain_done, 1);

    // Backpressure: fill, stall, then drain across pointer wrap
    do_reset();
    out_ready = 0; m_popped.delete();
    for (int k = 1; k <= DEPTH; k++) send(k, 3'(k));
    res_valid = 1; res_key = 9;
    step(); chk("full_ready0", res_ready, 0);
    step(); chk("full_ready1", res_ready, 0);
    out_ready = 1;
    send(9, 1); send(10, 1); idle();
    for (int n = 0; n < 20 && m_q.size() != 0; n++) step();
    chk("drain_cnt", m_popped.size(), 10);
    for (int k = 0; k < 10 && k < m_popped.size(); k++) chk("drain_order", m_popped[k], k + 1);

    // Steady state at 4 entries with simultaneous push and pop
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 4; k++) send(100 + k, 4);
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      send(104 + i, 4);
      chk("steady_head", out_key, 101 + i);
      chk("steady_occ", m_q.size(), 4);
    end
    idle(); out_ready = 0;

    // Outstanding errors and simultaneous fire/push
    do_reset();
    send(32'hdead, 6); idle(); step();
    chk("unexp_flag", err_unexp, 1);
    chk("unexp_outst", outstanding, 0);
    cmd_fire = 1; step(); step(); cmd_fire = 0;
    cmd_fire = 1; send(32'hbeef, 6); idle(); step();
    chk("fire_push_outst", outstanding, 2);
    chk("unexp_sticky", err_unexp, 1);

    // Statistics saturation and clear-wins
    do_reset();
    out_ready = 1; stat_sel = 5;
    for (int i = 0; i < 17; i++) begin cmd_fire = 1; send(200 + i, 5); end
    idle(); step();
    chk("stat_sat", stat_cnt, 15);
    stat_clr = 1; send(300, 5); idle(); step();
    chk("stat_clr_wins", stat_cnt, 0);

    // Outstanding counter overflow
    do_reset();
    cmd_fire = 1;
    for (int i = 0; i < 256; i++) step();
    idle(); step();
    chk("ovf_outst", outstanding, 255);
    chk("ovf_flag", err_ovf, 1);

    // Reset with buffered entries and commands pending
    do_reset();
    out_ready = 0; cmd_fire = 1;
    for (int i = 0; i < 8; i++) step();
    cmd_fire = 0;
    for (int k = 0; k < 5; k++) send(400 + k, 1);
    idle(); step();
    chk("pre_rst_outst", outstanding, 3);
    do_reset();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_outst", outstanding, 0);
    chk("post_rst_drain", drain_done, 1);
    chk("post_rst_ready", res_ready, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_fire    = ($urandom % 3) == 0;
      res_valid   = $urandom % 2;
      out_ready   = ($urandom % 4) != 0;
      res_opcode  = 2'($urandom);
      res_key     = $urandom;
      res_value   = 16'($urandom);
      res_rescode = 3'($urandom);
      stat_sel    = 3'($urandom);
      stat_clr    = ($urandom % 50) == 0;
      rst         = ($urandom % 300) == 0;
      step();
    end
    rst = 0; idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
